// File: rtl/div_pkg.sv
// Shared types and helpers for the signed restoring divider.
package div_pkg;

   localparam int unsigned DefWidth = 4;
   localparam int unsigned MaxW     = 64;
   localparam int unsigned IdxW     = $clog2(MaxW);

   typedef logic [MaxW-1:0] word_t;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StFix,
      StDone
   } state_e;

   function automatic word_t neg(input word_t x);
      return ~x + word_t'(1);
   endfunction

   // Magnitude of a w-bit two's complement value held in the low bits of x;
   // callers truncate the result back to w bits.
   function automatic word_t abs_val(input word_t x, input int unsigned w);
      return x[IdxW'(w - 1)] ? neg(x) : x;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
   parameter int unsigned WIDTH = div_pkg::DefWidth
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;
   logic             unused_trial_bit;

   assign shifted = {rem_i, bit_i};
   // Two guard bits so the borrow lands in the MSB and never wraps.
   assign trial   = {1'b0, shifted} - {2'b00, dvs_i};
   assign q_o     = ~trial[WIDTH+1];
   assign rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

   assign unused_trial_bit = trial[WIDTH];

endmodule

// File: rtl/signed_divider.sv
// Sequential signed radix-2 restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, with sign fix-up and range check after the magnitude loop.
module signed_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned CW    = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic [WIDTH-1:0]     quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic [CW-1:0]        count,
   output logic                 busy,
   output logic                 done,
   output logic                 div_by_zero,
   output logic                 overflow
);

   localparam logic [WIDTH-1:0] QLim = {1'b1, {(WIDTH-1){1'b0}}};

   state_e             state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   logic               dvd_neg_q, dvd_neg_d;
   logic               dvs_neg_q, dvs_neg_d;
   logic [WIDTH-1:0]   dvs_mag_q, dvs_mag_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   dlo_q, dlo_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   rmdr_q, rmdr_d;
   logic               dbz_q, dbz_d;
   logic               ovf_q, ovf_d;

   logic [2*WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0]   dvs_mag;
   logic [WIDTH-1:0]   step_rem;
   logic               step_q;
   logic               sign_diff;
   logic               in_range;

   assign dvd_mag   = (2*WIDTH)'(abs_val(word_t'(dividend), 2*WIDTH));
   assign dvs_mag   = WIDTH'(abs_val(word_t'(divisor), WIDTH));
   assign sign_diff = dvd_neg_q ^ dvs_neg_q;
   // -2^(WIDTH-1) is representable only when the result is negative.
   assign in_range  = sign_diff ? (dlo_q <= QLim) : (dlo_q < QLim);

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i (rem_q),
      .bit_i (dlo_q[WIDTH-1]),
      .dvs_i (dvs_mag_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      dvd_neg_d = dvd_neg_q;
      dvs_neg_d = dvs_neg_q;
      dvs_mag_d = dvs_mag_q;
      rem_d     = rem_q;
      dlo_d     = dlo_q;
      quot_d    = quot_q;
      rmdr_d    = rmdr_q;
      dbz_d     = dbz_q;
      ovf_d     = ovf_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               dvd_neg_d = dividend[2*WIDTH-1];
               dvs_neg_d = divisor[WIDTH-1];
               dvs_mag_d = dvs_mag;
               rem_d     = dvd_mag[2*WIDTH-1:WIDTH];
               dlo_d     = dvd_mag[WIDTH-1:0];
               count_d   = '0;
               dbz_d     = 1'b0;
               ovf_d     = 1'b0;
               state_d   = StBusy;
               if (divisor == '0) begin
                  dbz_d   = 1'b1;
                  quot_d  = '0;
                  rmdr_d  = '0;
                  state_d = StDone;
               end else if (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag) begin
                  ovf_d   = 1'b1;
                  quot_d  = '0;
                  rmdr_d  = '0;
                  state_d = StDone;
               end
            end
         end
         StBusy: begin
            rem_d = step_rem;
            dlo_d = {dlo_q[WIDTH-2:0], step_q};
            if (count_q == CW'(WIDTH - 1)) begin
               count_d = '0;
               state_d = StFix;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         StFix: begin
            state_d = StDone;
            if (!in_range) begin
               ovf_d  = 1'b1;
               quot_d = '0;
               rmdr_d = '0;
            end else begin
               quot_d = sign_diff ? WIDTH'(neg(word_t'(dlo_q))) : dlo_q;
               rmdr_d = dvd_neg_q ? WIDTH'(neg(word_t'(rem_q))) : rem_q;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         count_q   <= '0;
         dvd_neg_q <= 1'b0;
         dvs_neg_q <= 1'b0;
         dvs_mag_q <= '0;
         rem_q     <= '0;
         dlo_q     <= '0;
         quot_q    <= '0;
         rmdr_q    <= '0;
         dbz_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         dvd_neg_q <= dvd_neg_d;
         dvs_neg_q <= dvs_neg_d;
         dvs_mag_q <= dvs_mag_d;
         rem_q     <= rem_d;
         dlo_q     <= dlo_d;
         quot_q    <= quot_d;
         rmdr_q    <= rmdr_d;
         dbz_q     <= dbz_d;
         ovf_q     <= ovf_d;
      end
   end

   assign quotient    = quot_q;
   assign remainder   = rmdr_q;
   assign count       = count_q;
   assign busy        = (state_q == StBusy) || (state_q == StFix);
   assign done        = (state_q == StDone);
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_signed_divider.sv
// Bench for signed_divider: directed vector table, random operands against an integer
// reference model, and hand-written reset-abort and held-start sequences.
module tb_signed_divider;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [2*W-1:0] dividend;
   logic [W-1:0]   divisor;
   logic [W-1:0]   quotient;
   logic [W-1:0]   remainder;
   logic [1:0]     count;
   logic           busy;
   logic           done;
   logic           div_by_zero;
   logic           overflow;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [2*W-1:0] dvd;
      logic [W-1:0]   dvs;
      logic [W-1:0]   q;
      logic [W-1:0]   r;
      bit             dbz;
      bit             ovf;
      int             lat;
   } vec_t;

   always #5 clk = ~clk;

   signed_divider #(
      .WIDTH (W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .count       (count),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   function automatic void check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endfunction

   // Plain integer division: truncation toward zero, remainder takes dividend sign.
   function automatic void model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output bit dbz, output bit ovf, output int lat);
      int d, s, ad, as_, qi, ri;
      d   = int'($signed(dvd));
      s   = int'($signed(dvs));
      ad  = (d < 0) ? -d : d;
      as_ = (s < 0) ? -s : s;
      q = '0; r = '0; dbz = 1'b0; ovf = 1'b0; lat = W + 2;
      if (s == 0) begin
         dbz = 1'b1;
         lat = 1;
      end else if (ad / as_ >= (1 << W)) begin
         ovf = 1'b1;
         lat = 1;
      end else begin
         qi = d / s;
         ri = d % s;
         if (qi < -(1 << (W - 1)) || qi > (1 << (W - 1)) - 1) ovf = 1'b1;
         else begin
            q = W'(qi);
            r = W'(ri);
         end
      end
   endfunction

   task automatic run_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input bit edbz, input bit eovf, input int elat, input string name);
      int lat;
      int busy_cycles;
      @(negedge clk);
      dividend = dvd;
      divisor  = dvs;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start       = 1'b0;
      dividend    = 8'($urandom);
      divisor     = 4'($urandom);
      lat         = 1;
      busy_cycles = busy ? 1 : 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) busy_cycles++;
      end
      check({name, " latency"}, lat, elat);
      check({name, " quotient"}, int'(quotient), int'(eq));
      check({name, " remainder"}, int'(remainder), int'(er));
      check({name, " div_by_zero"}, int'(div_by_zero), int'(edbz));
      check({name, " overflow"}, int'(overflow), int'(eovf));
      check({name, " busy cycles"}, busy_cycles, elat - 1);
      @(posedge clk);
      #1;
      check({name, " done pulse width"}, int'(done), 0);
   endtask

   initial begin
      vec_t           tbl[10];
      logic [2*W-1:0] rdvd;
      logic [W-1:0]   rdvs;
      logic [W-1:0]   mq;
      logic [W-1:0]   mr;
      bit             mdbz;
      bit             movf;
      int             mlat;
      int             m;
      int             guard;
      int             seen;
      int             lat;

      tbl[0] = '{8'd20,  4'd5,  4'd4,  4'd0,  1'b0, 1'b0, 6};
      tbl[1] = '{8'hF9,  4'd2,  4'hD,  4'hF,  1'b0, 1'b0, 6};
      tbl[2] = '{8'd7,   4'hE,  4'hD,  4'd1,  1'b0, 1'b0, 6};
      tbl[3] = '{8'd64,  4'h8,  4'h8,  4'd0,  1'b0, 1'b0, 6};
      tbl[4] = '{8'hC0,  4'h8,  4'd0,  4'd0,  1'b0, 1'b1, 6};
      tbl[5] = '{8'd100, 4'd3,  4'd0,  4'd0,  1'b0, 1'b1, 1};
      tbl[6] = '{8'h37,  4'd0,  4'd0,  4'd0,  1'b1, 1'b0, 1};
      tbl[7] = '{8'd15,  4'd4,  4'd3,  4'd3,  1'b0, 1'b0, 6};
      tbl[8] = '{8'h80,  4'h8,  4'd0,  4'd0,  1'b0, 1'b1, 1};
      tbl[9] = '{8'hC4,  4'd7,  4'h8,  4'hC,  1'b0, 1'b0, 6};

      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset quotient", int'(quotient), 0);
      check("reset remainder", int'(remainder), 0);
      check("reset count", int'(count), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset flags", int'({div_by_zero, overflow}), 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i].dvd, tbl[i].dvs, tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].ovf,
                tbl[i].lat, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 40; i++) begin
         rdvs = 4'($urandom);
         if (i % 2 == 0) begin
            m    = int'($urandom_range(0, 63));
            rdvd = $urandom_range(0, 1) ? 8'(-m) : 8'(m);
         end else begin
            rdvd = 8'($urandom);
         end
         model(rdvd, rdvs, mq, mr, mdbz, movf, mlat);
         run_op(rdvd, rdvs, mq, mr, mdbz, movf, mlat, $sformatf("rand%0d", i));
      end

      // Reset in the middle of an operation aborts it asynchronously.
      run_op(8'd20, 4'd5, 4'd4, 4'd0, 1'b0, 1'b0, 6, "pre-abort");
      @(negedge clk);
      dividend = 8'd20;
      divisor  = 4'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      guard = 0;
      while (count != 2'd2 && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("abort reach count 2", int'(count), 2);
      #2;
      reset = 1'b1;
      #1;
      check("abort quotient", int'(quotient), 0);
      check("abort remainder", int'(remainder), 0);
      check("abort count", int'(count), 0);
      check("abort busy", int'(busy), 0);
      check("abort done", int'(done), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen  = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done) seen = 1;
      end
      check("abort no done", seen, 0);
      run_op(8'd15, 4'd4, 4'd3, 4'd3, 1'b0, 1'b0, 6, "post-abort");

      // Start held high: operands captured at the start edge, relaunch after DONE.
      @(negedge clk);
      dividend = 8'd20;
      divisor  = 4'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
      lat = 1;
      @(negedge clk);
      dividend = 8'd15;
      divisor  = 4'd4;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("held first latency", lat, 6);
      check("held first quotient", int'(quotient), 4);
      check("held first remainder", int'(remainder), 0);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!done && lat < 20);
      start = 1'b0;
      check("held relaunch latency", lat, 7);
      check("held second quotient", int'(quotient), 3);
      check("held second remainder", int'(remainder), 3);
      repeat (2) @(posedge clk);
      #1;
      check("held idle busy", int'(busy), 0);
      check("held idle done", int'(done), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
